// File: rtl/led_display_scanner_pkg.sv
// Shared display definitions: segment codes, blank pattern and digit count.
// Imported by the scanner top and the hex_to_seg7 decoder.
package led_display_scanner_pkg;

  localparam int unsigned DIGIT_NUM = 8;
  localparam logic [7:0]  SEG_BLANK = 8'hFF;

  // Active-low g..a codes, decimal point excluded
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  function automatic logic [7:0] anode_sel(input logic [2:0] idx);
    return ~(8'b1 << idx);
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low 7-segment (g..a) decoder.
module hex_to_seg7
  import led_display_scanner_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = SEG_0;
    unique case (nibble_i)
      4'h0: seg_n_o = SEG_0;
      4'h1: seg_n_o = SEG_1;
      4'h2: seg_n_o = SEG_2;
      4'h3: seg_n_o = SEG_3;
      4'h4: seg_n_o = SEG_4;
      4'h5: seg_n_o = SEG_5;
      4'h6: seg_n_o = SEG_6;
      4'h7: seg_n_o = SEG_7;
      4'h8: seg_n_o = SEG_8;
      4'h9: seg_n_o = SEG_9;
      4'hA: seg_n_o = SEG_A;
      4'hB: seg_n_o = SEG_B;
      4'hC: seg_n_o = SEG_C;
      4'hD: seg_n_o = SEG_D;
      4'hE: seg_n_o = SEG_E;
      4'hF: seg_n_o = SEG_F;
      default: seg_n_o = SEG_0;
    endcase
  end

endmodule

// File: rtl/led_display_scanner.sv
// Captures the CPU LED word at frame boundaries and scans it as 8 hex digits.
// Optional LEADING_ZERO_BLANK_EN blanks leading-zero digits above digit 0.
module led_display_scanner
  import led_display_scanner_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100000,
  parameter int unsigned DIGITS  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] led_data_in,
  input  logic        led_cpu_enable,
  input  logic        display_hold,
  output logic [7:0]  an_n,
  output logic [7:0]  seg_n,
  output logic [15:0] frame_count
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (DIGITS != DIGIT_NUM) begin : g_bad_digits
    $error("led_display_scanner: DIGITS must be 8");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("led_display_scanner: CLK_DIV must be >= 1");
  end

  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [2:0]    digit_idx_q, digit_idx_d;
  logic [31:0]   frame_reg_q, frame_reg_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic [7:0]    an_n_q, an_n_d;
  logic [7:0]    seg_n_q, seg_n_d;

  logic          tick;
  logic [3:0]    cur_nibble;
  logic [6:0]    cur_code;
  logic [31:0]   upper_bits;
  logic          blank;

  assign cur_nibble = frame_reg_q[{digit_idx_q, 2'b00} +: 4];
  assign upper_bits = frame_reg_q >> {digit_idx_q, 2'b00};

  hex_to_seg7 u_hex_to_seg7 (
    .nibble_i (cur_nibble),
    .seg_n_o  (cur_code)
  );

  always_comb begin
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    // Digit 0 is never blanked so an all-zero word still shows "0"
    blank = (digit_idx_q != 3'd0) && (upper_bits == 32'd0);
`endif
  end

  always_comb begin
    tick          = (prescaler_q == PW'(CLK_DIV - 1));
    prescaler_d   = tick ? '0 : prescaler_q + 1'b1;
    digit_idx_d   = tick ? digit_idx_q + 3'd1 : digit_idx_q;
    frame_reg_d   = frame_reg_q;
    frame_count_d = frame_count_q;

    if (tick && (digit_idx_q == 3'd7) && led_cpu_enable && !display_hold) begin
      frame_reg_d   = led_data_in;
      frame_count_d = frame_count_q + 16'd1;
    end

    an_n_d  = anode_sel(digit_idx_q);
    seg_n_d = {1'b1, cur_code};
    if (blank) begin
      an_n_d  = SEG_BLANK;
      seg_n_d = SEG_BLANK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler_q   <= '0;
      digit_idx_q   <= 3'd0;
      frame_reg_q   <= 32'd0;
      frame_count_q <= 16'd0;
      an_n_q        <= 8'hFF;
      seg_n_q       <= 8'hFF;
    end else begin
      prescaler_q   <= prescaler_d;
      digit_idx_q   <= digit_idx_d;
      frame_reg_q   <= frame_reg_d;
      frame_count_q <= frame_count_d;
      an_n_q        <= an_n_d;
      seg_n_q       <= seg_n_d;
    end
  end

  assign an_n        = an_n_q;
  assign seg_n       = seg_n_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_led_display_scanner.sv
// Self-checking bench for led_display_scanner (CLK_DIV=4): directed frame
// scenarios followed by randomized data/enable/hold against a frame-level model.
module tb_led_display_scanner;

  localparam int unsigned CLK_DIV = 4;

  logic        clk;
  logic        rst;
  logic [31:0] data;
  logic        en;
  logic        hold;
  logic [7:0]  an_n;
  logic [7:0]  seg_n;
  logic [15:0] frame_count;

  int unsigned n_tests;
  int unsigned n_fail;

  // Model state: clock edges since reset release, captured word, capture count
  int unsigned n_edges;
  logic [31:0] frame_m;
  logic [15:0] fc_m;

  led_display_scanner #(
    .CLK_DIV (CLK_DIV),
    .DIGITS  (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .led_data_in    (data),
    .led_cpu_enable (en),
    .display_hold   (hold),
    .an_n           (an_n),
    .seg_n          (seg_n),
    .frame_count    (frame_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", tag, act, exp, n_edges);
    end
  endtask

  function automatic logic [7:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: return 8'hC0;
      4'h1: return 8'hF9;
      4'h2: return 8'hA4;
      4'h3: return 8'hB0;
      4'h4: return 8'h99;
      4'h5: return 8'h92;
      4'h6: return 8'h82;
      4'h7: return 8'hF8;
      4'h8: return 8'h80;
      4'h9: return 8'h90;
      4'hA: return 8'h88;
      4'hB: return 8'h83;
      4'hC: return 8'hC6;
      4'hD: return 8'hA1;
      4'hE: return 8'h86;
      default: return 8'h8E;
    endcase
  endfunction

  task automatic model_reset();
    n_edges = 0;
    frame_m = 32'd0;
    fc_m    = 16'd0;
  endtask

  // Predict the pins after the next rising edge, then sample at the following negedge.
  task automatic step();
    int unsigned slot;
    logic [7:0]  exp_an;
    logic [7:0]  exp_seg;
    logic        blank;
    n_edges++;
    slot = ((n_edges - 1) / CLK_DIV) % 8;
    for (int i = 0; i < 8; i++) exp_an[i] = (i != slot);
    exp_seg = hex_seg(frame_m[4*slot +: 4]);
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank = (slot != 0) && ((frame_m >> (4 * slot)) == 32'd0);
`endif
    if (blank) begin
      exp_an  = 8'hFF;
      exp_seg = 8'hFF;
    end
    if ((n_edges % (8 * CLK_DIV)) == 0 && en && !hold) begin
      frame_m = data;
      fc_m    = fc_m + 16'd1;
    end
    @(negedge clk);
    check_val("an_n", {24'd0, an_n}, {24'd0, exp_an});
    check_val("seg_n", {24'd0, seg_n}, {24'd0, exp_seg});
    check_val("frame_count", {16'd0, frame_count}, {16'd0, fc_m});
  endtask

  task automatic async_reset_pulse();
    #2 rst = 1'b1;
    #1;
    check_val("rst_an_n", {24'd0, an_n}, 32'hFF);
    check_val("rst_seg_n", {24'd0, seg_n}, 32'hFF);
    check_val("rst_frame_count", {16'd0, frame_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst  = 1'b1;
    en   = 1'b0;
    hold = 1'b0;
    data = 32'd0;
    model_reset();

    #1;
    check_val("init_an_n", {24'd0, an_n}, 32'hFF);
    check_val("init_seg_n", {24'd0, seg_n}, 32'hFF);
    check_val("init_frame_count", {16'd0, frame_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed: capture, mid-frame data change, held boundary, later capture
    data = 32'h89AB_CDEF;
    en   = 1'b1;
    step();
    check_val("first_an_n", {24'd0, an_n}, 32'hFE);
    check_val("first_seg_n", {24'd0, seg_n}, 32'hC0);
    while (n_edges < 100) begin
      if (n_edges == 39) data = 32'h1234_5678;
      hold = (n_edges == 63);
      step();
      if (n_edges == 32) check_val("fc_after_32", {16'd0, frame_count}, 32'd1);
      if (n_edges == 64) check_val("fc_held_64", {16'd0, frame_count}, 32'd1);
      if (n_edges == 96) check_val("fc_after_96", {16'd0, frame_count}, 32'd2);
    end

    async_reset_pulse();

    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) data = $urandom >> $urandom_range(0, 31);
      en   = ($urandom_range(0, 3) != 0);
      hold = ($urandom_range(0, 3) == 0);
      step();
      if ($urandom_range(0, 499) == 0) async_reset_pulse();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
